// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host write path and serial/status signals of the TX FIFO.
// The host side drives data and strobes; the transmitter reports line and flags.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] Tx_Data;
  logic                 Load_Data;
  logic                 BIST_Mode;
  logic                 Tx_Serial;
  logic                 Tx_Busy;
  logic                 FIFO_Empty;
  logic                 FIFO_Full;
  logic                 FIFO_Overflow;

  modport master (
    output Tx_Data,
    output Load_Data,
    output BIST_Mode,
    input  Tx_Serial,
    input  Tx_Busy,
    input  FIFO_Empty,
    input  FIFO_Full,
    input  FIFO_Overflow
  );

  modport slave (
    input  Tx_Data,
    input  Load_Data,
    input  BIST_Mode,
    output Tx_Serial,
    output Tx_Busy,
    output FIFO_Empty,
    output FIFO_Full,
    output FIFO_Overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
// Host bytes queue in a circular buffer and leave LSB-first framed on Tx_Serial.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_WIDTH   = 2,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int ENTRIES = 1 << FIFO_WIDTH;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [FIFO_WIDTH:0] FULL_CNT =
    (FIFO_WIDTH+1)'(ENTRIES);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_MAX = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic [DATA_BITS-1:0]  mem_q [ENTRIES];
  logic [FIFO_WIDTH-1:0] wr_q;
  logic [FIFO_WIDTH-1:0] rd_q;
  logic [FIFO_WIDTH:0]   cnt_q;
  logic [FIFO_WIDTH:0]   cnt_d;
  state_e                state_q;
  logic [BW-1:0]         baud_q;
  logic [IW-1:0]         bit_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic [DATA_BITS-1:0]  shift_nxt;
  logic [DATA_BITS-1:0]  head;
  logic                  par_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  empty_q;
  logic                  full_q;
  logic                  ovf_q;
  logic                  baud_end;
  logic                  can_start;
  logic                  pop;
  logic                  wr_en;
  logic                  push;
  logic                  drop;

  assign head = mem_q[rd_q];

  always_comb begin
    baud_end  = (baud_q == BAUD_MAX);
    can_start = (cnt_q != '0) && !bus.BIST_Mode;
    pop = can_start &&
          ((state_q == IDLE) ||
           ((state_q == STOP) && baud_end));
    wr_en = bus.Load_Data && !bus.BIST_Mode;
    push  = wr_en && ((cnt_q != FULL_CNT) || pop);
    drop  = wr_en && !push;
    cnt_d = cnt_q
          + (FIFO_WIDTH+1)'(push)
          - (FIFO_WIDTH+1)'(pop);
    shift_nxt = shift_q >> 1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.Tx_Data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == FULL_CNT);
      if (push) wr_q <= wr_q + 1'b1;
      if (drop) ovf_q <= 1'b1;
      else if (pop) ovf_q <= 1'b0;
      // parity is latched at pop so the data shift can destroy the byte
      if (pop) begin
        rd_q    <= rd_q + 1'b1;
        shift_q <= head;
        par_q   <= ^head;
      end
      if (state_q == IDLE) begin
        baud_q <= '0;
        if (pop) begin
          state_q <= START;
          tx_q    <= 1'b0;
          busy_q  <= 1'b1;
        end
      end else if (!baud_end) begin
        baud_q <= baud_q + 1'b1;
      end else begin
        baud_q <= '0;
        unique case (state_q)
          START: begin
            state_q <= DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
          DATA: begin
            if (bit_q == BIT_MAX) begin
              if (PARITY_EN != 0) begin
                state_q <= PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_nxt;
              tx_q    <= shift_nxt[0];
            end
          end
          PARITY: begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
          STOP: begin
            if (pop) begin
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Tx_Serial     = tx_q;
  assign bus.Tx_Busy       = busy_q;
  assign bus.FIFO_Empty    = empty_q;
  assign bus.FIFO_Full     = full_q;
  assign bus.FIFO_Overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: checks two transmitter configurations against
// a queue-of-samples line model and directed frame expectations.
module tb_uart_tx_fifo;
  localparam int CA = 4;
  localparam int CB = 3;
  localparam int FA = 2 + 8 + 1;

  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;

  uart_tx_fifo_if #(.DATA_BITS(8)) ifa ();
  uart_tx_fifo_if #(.DATA_BITS(7)) ifb ();

  uart_tx_fifo #(
    .DATA_BITS(8), .FIFO_WIDTH(2),
    .CLKS_PER_BIT(CA), .PARITY_EN(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  uart_tx_fifo #(
    .DATA_BITS(7), .FIFO_WIDTH(2),
    .CLKS_PER_BIT(CB), .PARITY_EN(0)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  // model: pending bytes and the remaining line samples of the current frame
  logic [7:0] mq[$];
  logic       mw[$];
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_ovf = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mw.delete();
    m_tx = 1'b1;
    m_busy = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic build_frame(input logic [7:0] d);
    logic b;
    for (int k = 0; k < FA; k++) begin
      if (k == 0) b = 1'b0;
      else if (k <= 8) b = d[k-1];
      else if (k == 9) b = ^d;
      else b = 1'b1;
      repeat (CA) mw.push_back(b);
    end
  endtask

  task automatic model_edge(input logic ld,
                            input logic [7:0] d,
                            input logic bist);
    if (mw.size() > 0) begin
      m_tx = mw.pop_front();
      m_busy = 1'b1;
    end else if (mq.size() > 0 && !bist) begin
      build_frame(mq.pop_front());
      m_ovf = 1'b0;
      m_tx = mw.pop_front();
      m_busy = 1'b1;
    end else begin
      m_tx = 1'b1;
      m_busy = 1'b0;
    end
    if (ld && !bist) begin
      if (mq.size() < 4) mq.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_a();
    chk("a_tx", ifa.Tx_Serial, m_tx);
    chk("a_busy", ifa.Tx_Busy, m_busy);
    chk("a_empty", ifa.FIFO_Empty, mq.size() == 0);
    chk("a_full", ifa.FIFO_Full, mq.size() == 4);
    chk("a_ovf", ifa.FIFO_Overflow, m_ovf);
  endtask

  task automatic cyc(input logic ld,
                     input logic [7:0] d,
                     input logic bist);
    ifa.Load_Data = ld;
    ifa.Tx_Data = d;
    ifa.BIST_Mode = bist;
    @(posedge clk);
    model_edge(ld, d, bist);
    #1;
    check_a();
  endtask

  initial begin
    logic [7:0] r8;
    logic       rb;
    logic [6:0] bv;
    logic       eb;
    int         bi;
    rst = 1'b1;
    ifa.Load_Data = 1'b0;
    ifa.Tx_Data = '0;
    ifa.BIST_Mode = 1'b0;
    ifb.Load_Data = 1'b0;
    ifb.Tx_Data = '0;
    ifb.BIST_Mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_a();
    chk("b_rst_tx", ifb.Tx_Serial, 1'b1);
    chk("b_rst_busy", ifb.Tx_Busy, 1'b0);
    chk("b_rst_empty", ifb.FIFO_Empty, 1'b1);
    chk("b_rst_ovf", ifb.FIFO_Overflow, 1'b0);

    cyc(1'b1, 8'hA5, 1'b0);
    repeat (50) cyc(1'b0, 8'h00, 1'b0);

    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    repeat (100) cyc(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    chk("ovf_set", ifa.FIFO_Overflow, 1'b1);
    chk("ovf_full", ifa.FIFO_Full, 1'b1);
    repeat (5 * FA * CA + 10) cyc(1'b0, 8'h00, 1'b0);

    cyc(1'b1, 8'h33, 1'b0);
    cyc(1'b1, 8'h44, 1'b0);
    repeat (8) cyc(1'b0, 8'h00, 1'b0);
    repeat (30) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h55, 1'b1);
    repeat (30) cyc(1'b0, 8'h00, 1'b1);
    chk("bist_hold", ifa.Tx_Serial, 1'b1);
    repeat (100) cyc(1'b0, 8'h00, 1'b0);
    chk("bist_drain", ifa.FIFO_Empty, 1'b1);

    cyc(1'b1, 8'hC3, 1'b0);
    repeat (10) cyc(1'b0, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx", ifa.Tx_Serial, 1'b1);
    chk("arst_busy", ifa.Tx_Busy, 1'b0);
    chk("arst_empty", ifa.FIFO_Empty, 1'b1);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    check_a();

    for (int blk = 0; blk < 30; blk++) begin
      rb = ($urandom_range(0, 5) == 0);
      for (int j = 0; j < 16; j++) begin
        r8 = 8'($urandom);
        cyc($urandom_range(0, 3) == 0, r8, rb);
      end
    end
    repeat (5 * FA * CA + 10) cyc(1'b0, 8'h00, 1'b0);

    for (int n = 0; n < 2; n++) begin
      bv = (n == 0) ? 7'h7F : 7'h05;
      ifb.Load_Data = 1'b1;
      ifb.Tx_Data = bv;
      cyc(1'b0, 8'h00, 1'b0);
      ifb.Load_Data = 1'b0;
      chk("b_load_empty", ifb.FIFO_Empty, 1'b0);
      for (int i = 0; i < 9 * CB; i++) begin
        cyc(1'b0, 8'h00, 1'b0);
        bi = i / CB;
        if (bi == 0) eb = 1'b0;
        else if (bi == 8) eb = 1'b1;
        else eb = bv[bi-1];
        chk("b_tx", ifb.Tx_Serial, eb);
        chk("b_busy", ifb.Tx_Busy, 1'b1);
      end
      cyc(1'b0, 8'h00, 1'b0);
      chk("b_end_busy", ifb.Tx_Busy, 1'b0);
      chk("b_end_tx", ifb.Tx_Serial, 1'b1);
      chk("b_end_empty", ifb.FIFO_Empty, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
